exec_ctrl: RTL and testbench

Execution controller for the single-cycle RV32I core: decides, cycle by cycle, whether the core executes the instruction at the current PC. It supports free-run, halt, N-instruction single-step and one PC breakpoint, driven by a valid/ready command port from the board debug/switch logic. It sits beside the core. Its `core_en_o` gates the PC register update, register-file write and dmem store enable, and its `pc_i` input is fed from the core's debug PC output.

---
 rtl/exec_ctrl_pkg.sv | 29 ++
 rtl/exec_bp_unit.sv | 40 ++++
 rtl/exec_ctrl.sv | 131 +++++++++++++
 tb/tb_exec_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared types for the execution controller: FSM states, command opcodes
// and halt causes.
package exec_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } exec_state_e;

    typedef enum logic [2:0] {
        OP_RUN     = 3'd0,
        OP_HALT    = 3'd1,
        OP_STEP    = 3'd2,
        OP_SET_BP  = 3'd3,
        OP_CLR_BP  = 3'd4,
        OP_CLR_CNT = 3'd5,
        OP_RSVD6   = 3'd6,
        OP_RSVD7   = 3'd7
    } exec_op_e;

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'd0,
        CAUSE_CMD       = 2'd1,
        CAUSE_STEP_DONE = 2'd2,
        CAUSE_BREAK     = 2'd3
    } halt_cause_e;

endpackage

// File: rtl/exec_bp_unit.sv
// Single PC breakpoint: address register, armed flag, resume-skip flag and
// the equality compare. Only instantiated when EXEC_CTRL_BP_EN is defined.
module exec_bp_unit #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         set_bp,
    input  logic         clr_bp,
    input  logic [W-1:0] bp_addr,
    input  logic [W-1:0] pc,
    input  logic         halted,
    output logic         bp_hit
);

    logic [W-1:0] addr_reg;
    logic         armed_reg;
    logic         skip_reg;

    // Breakpoint storage; skip is set for the first cycle after leaving HALT
    // so that resuming from a breakpoint executes the trapped instruction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_reg  <= '0;
            armed_reg <= 1'b0;
            skip_reg  <= 1'b1;
        end else begin
            if (set_bp) begin
                addr_reg  <= bp_addr;
                armed_reg <= 1'b1;
            end else if (clr_bp) begin
                armed_reg <= 1'b0;
            end
            skip_reg <= halted;
        end
    end

    assign bp_hit = armed_reg && !halted && !skip_reg && (pc == addr_reg);

endmodule

// File: rtl/exec_ctrl.sv
// Execution controller for the RV32I core: free-run, halt, N-step and an
// optional PC breakpoint (built only when EXEC_CTRL_BP_EN is defined).
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int W         = 32,
    parameter bit START_RUN = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [2:0]   cmd_op_i,
    input  logic [W-1:0] cmd_arg_i,
    input  logic [W-1:0] pc_i,
    output logic         core_en_o,
    output logic         halted_o,
    output logic [1:0]   halt_cause_o,
    output logic [W-1:0] retired_o
);

    exec_state_e  state_reg, state_next;
    halt_cause_e  cause_reg, cause_next;
    logic [W-1:0] remaining_reg, remaining_next;
    logic [W-1:0] retired_reg;
    exec_op_e     op;
    logic         cmd_fire;
    logic         bp_hit;

    assign op           = exec_op_e'(cmd_op_i);
    assign cmd_ready_o  = (state_reg != ST_STEP);
    assign cmd_fire     = cmd_valid_i && cmd_ready_o;
    assign halted_o     = (state_reg == ST_HALT);
    assign core_en_o    = !halted_o && !bp_hit;
    assign halt_cause_o = cause_reg;
    assign retired_o    = retired_reg;

`ifdef EXEC_CTRL_BP_EN
    logic set_bp;
    logic clr_bp;

    assign set_bp = cmd_fire && (op == OP_SET_BP);
    assign clr_bp = cmd_fire && (op == OP_CLR_BP);

    exec_bp_unit #(
        .W(W)
    ) u_bp (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .set_bp  (set_bp),
        .clr_bp  (clr_bp),
        .bp_addr (cmd_arg_i),
        .pc      (pc_i),
        .halted  (halted_o),
        .bp_hit  (bp_hit)
    );
`else
    // Without the breakpoint hardware the PC is not observed at all.
    logic unused_pc;
    assign unused_pc = ^pc_i;
    assign bp_hit    = 1'b0;
`endif

    // State, cause and step-count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= START_RUN ? ST_RUN : ST_HALT;
            cause_reg     <= CAUSE_NONE;
            remaining_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cause_reg     <= cause_next;
            remaining_reg <= remaining_next;
        end
    end

    // Next-state logic; a breakpoint hit outranks any command or step end.
    always_comb begin
        state_next     = state_reg;
        cause_next     = cause_reg;
        remaining_next = remaining_reg;
        case (state_reg)
            ST_HALT: begin
                if (cmd_fire && (op == OP_RUN)) begin
                    state_next = ST_RUN;
                end else if (cmd_fire && (op == OP_STEP)) begin
                    state_next     = ST_STEP;
                    remaining_next = (cmd_arg_i == '0) ? W'(1) : cmd_arg_i;
                end
            end
            ST_RUN: begin
                if (bp_hit) begin
                    state_next = ST_HALT;
                    cause_next = CAUSE_BREAK;
                end else if (cmd_fire && (op == OP_HALT)) begin
                    state_next = ST_HALT;
                    cause_next = CAUSE_CMD;
                end
            end
            ST_STEP: begin
                if (bp_hit) begin
                    state_next     = ST_HALT;
                    cause_next     = CAUSE_BREAK;
                    remaining_next = '0;
                end else begin
                    remaining_next = remaining_reg - W'(1);
                    if (remaining_reg <= W'(1)) begin
                        state_next     = ST_HALT;
                        cause_next     = CAUSE_STEP_DONE;
                        remaining_next = '0;
                    end
                end
            end
            default: begin
                state_next = ST_HALT;
            end
        endcase
    end

    // Retired-instruction counter; a clear wins over a same-cycle retirement.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retired_reg <= '0;
        end else if (cmd_fire && (op == OP_CLR_CNT)) begin
            retired_reg <= '0;
        end else if (core_en_o) begin
            retired_reg <= retired_reg + W'(1);
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: a behavioural model checked every cycle, directed
// command sequences with literal expectations, and a W=8 instance for wrap.
`timescale 1ns/1ps
module tb_exec_ctrl;

    localparam int W = 32;
`ifdef EXEC_CTRL_BP_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    localparam logic [2:0] C_RUN     = 3'd0;
    localparam logic [2:0] C_HALT    = 3'd1;
    localparam logic [2:0] C_STEP    = 3'd2;
    localparam logic [2:0] C_SET_BP  = 3'd3;
    localparam logic [2:0] C_CLR_BP  = 3'd4;
    localparam logic [2:0] C_CLR_CNT = 3'd5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [2:0]   cmd_op = 3'd0;
    logic [W-1:0] cmd_arg = '0;
    logic [W-1:0] pc = '0;
    logic         cmd_ready, core_en, halted;
    logic [1:0]   halt_cause;
    logic [W-1:0] retired;

    logic         rst8_n = 1'b1;
    logic         valid8 = 1'b0;
    logic [2:0]   op8 = 3'd0;
    logic [7:0]   arg8 = 8'd0;
    logic [7:0]   pc8 = 8'd0;
    logic         ready8, en8, halted8;
    logic [1:0]   cause8;
    logic [7:0]   retired8;

    logic         pc_load = 1'b1;
    logic [W-1:0] pc_load_val = '0;
    int           cyc8 = 0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exec_ctrl #(.W(W), .START_RUN(1'b0)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_arg_i    (cmd_arg),
        .pc_i         (pc),
        .core_en_o    (core_en),
        .halted_o     (halted),
        .halt_cause_o (halt_cause),
        .retired_o    (retired)
    );

    exec_ctrl #(.W(8), .START_RUN(1'b1)) dut8 (
        .clk_i        (clk),
        .rst_ni       (rst8_n),
        .cmd_valid_i  (valid8),
        .cmd_ready_o  (ready8),
        .cmd_op_i     (op8),
        .cmd_arg_i    (arg8),
        .pc_i         (pc8),
        .core_en_o    (en8),
        .halted_o     (halted8),
        .halt_cause_o (cause8),
        .retired_o    (retired8)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Stand-in for the core's PC: advances by 4 whenever the core commits.
    always @(posedge clk) begin
        if (pc_load) pc <= pc_load_val;
        else if (core_en) pc <= pc + 32'd4;
    end

    always @(posedge clk) begin
        if (rst8_n) cyc8 <= cyc8 + 1;
    end

    // Behavioural model: halted flag, steps left (-1 = free run), breakpoint.
    bit           m_halted = 1'b1;
    longint       m_left = -1;
    bit           m_armed = 1'b0;
    bit           m_fresh = 1'b1;
    logic [W-1:0] m_bp = '0;
    logic [1:0]   m_cause = 2'd0;
    logic [W-1:0] m_ret = '0;
    logic [7:0]   m8 = 8'd0;

    always @(negedge clk) begin
        bit hit, en, rdy, fire, nfresh;
        if (!rst_n) begin
            m_halted = 1'b1; m_left = -1; m_armed = 1'b0; m_fresh = 1'b1;
            m_cause = 2'd0; m_ret = '0;
        end
        hit = BP_EN && m_armed && !m_halted && !m_fresh && (pc == m_bp);
        en  = !m_halted && !hit;
        rdy = m_halted || (m_left < 0);
        check("m_core_en", {63'd0, core_en}, {63'd0, en});
        check("m_ready", {63'd0, cmd_ready}, {63'd0, rdy});
        check("m_halted", {63'd0, halted}, {63'd0, m_halted});
        check("m_cause", {62'd0, halt_cause}, {62'd0, m_cause});
        check("m_retired", {32'd0, retired}, {32'd0, m_ret});
        if (rst_n) begin
            fire   = cmd_valid && rdy;
            nfresh = m_halted;
            m_ret  = (fire && cmd_op == C_CLR_CNT) ? '0 : m_ret + (en ? 32'd1 : 32'd0);
            if (hit) begin
                m_halted = 1'b1; m_cause = 2'd3; m_left = -1;
            end else if (m_halted) begin
                if (fire && cmd_op == C_RUN) begin
                    m_halted = 1'b0; m_left = -1;
                end else if (fire && cmd_op == C_STEP) begin
                    m_halted = 1'b0;
                    m_left = (cmd_arg == '0) ? 1 : longint'(cmd_arg);
                end
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_halted = 1'b1; m_cause = 2'd2; m_left = -1;
                end
            end else if (fire && cmd_op == C_HALT) begin
                m_halted = 1'b1; m_cause = 2'd1;
            end
            if (fire && cmd_op == C_SET_BP) begin
                m_armed = 1'b1; m_bp = cmd_arg;
            end
            if (fire && cmd_op == C_CLR_BP) m_armed = 1'b0;
            m_fresh = nfresh;
        end
    end

    // The W=8 instance free-runs from reset; its counter is cycles mod 256.
    always @(negedge clk) begin
        if (!rst8_n) m8 = 8'd0;
        check("w8_en", {63'd0, en8}, 64'd1);
        check("w8_halted", {63'd0, halted8}, 64'd0);
        check("w8_ready", {63'd0, ready8}, 64'd1);
        check("w8_cause", {62'd0, cause8}, 64'd0);
        check("w8_retired", {56'd0, retired8}, {56'd0, m8});
        if (rst8_n) m8 = m8 + 8'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [W-1:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic load_pc(input logic [W-1:0] v);
        pc_load     = 1'b1;
        pc_load_val = v;
        tick();
        pc_load     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        rst_n  = 1'b0;
        rst8_n = 1'b0;
        #1;
        check("rst_core_en", {63'd0, core_en}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd1);
        check("rst_cause", {62'd0, halt_cause}, 64'd0);
        check("rst_retired", {32'd0, retired}, 64'd0);
        check("rst8_core_en", {63'd0, en8}, 64'd1);
        check("rst8_halted", {63'd0, halted8}, 64'd0);
        repeat (3) tick();
        rst_n   = 1'b1;
        rst8_n  = 1'b1;
        pc_load = 1'b0;

        // Free run from HALT: 10 retirements 11 cycles after the RUN.
        tick();
        check("t1_en_before_run", {63'd0, core_en}, 64'd0);
        send(C_RUN, '0);
        check("t1_en_after_run", {63'd0, core_en}, 64'd1);
        repeat (10) tick();
        check("t1_retired_10", {32'd0, retired}, 64'd10);
        send(C_HALT, '0);
        check("t1_halted", {63'd0, halted}, 64'd1);
        check("t1_cause_cmd", {62'd0, halt_cause}, 64'd1);
        check("t1_retired_11", {32'd0, retired}, 64'd11);

        // STEP 3 then STEP 0.
        send(C_STEP, 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("t2_step3_en", {63'd0, core_en}, 64'd1);
            check("t2_step3_ready", {63'd0, cmd_ready}, 64'd0);
            tick();
        end
        check("t2_step3_halted", {63'd0, halted}, 64'd1);
        check("t2_step3_cause", {62'd0, halt_cause}, 64'd2);
        check("t2_step3_retired", {32'd0, retired}, 64'd14);
        send(C_STEP, 32'd0);
        check("t2_step0_en", {63'd0, core_en}, 64'd1);
        tick();
        check("t2_step0_halted", {63'd0, halted}, 64'd1);
        check("t2_step0_retired", {32'd0, retired}, 64'd15);

        // Breakpoint at 0x10, then resume through it.
        load_pc(32'h0);
        send(C_SET_BP, 32'h10);
        send(C_RUN, '0);
        repeat (4) tick();
        check("t3_pc_at_bp", {32'd0, pc}, 64'h10);
        check("t3_en_at_bp", {63'd0, core_en}, BP_EN ? 64'd0 : 64'd1);
        tick();
        check("t3_halted_bp", {63'd0, halted}, BP_EN ? 64'd1 : 64'd0);
        check("t3_cause_bp", {62'd0, halt_cause}, BP_EN ? 64'd3 : 64'd2);
        check("t3_retired_bp", {32'd0, retired}, BP_EN ? 64'd19 : 64'd20);
        send(C_RUN, '0);
        check("t3_resume_en", {63'd0, core_en}, 64'd1);
        repeat (4) tick();
        check("t3_no_retrigger", {63'd0, halted}, 64'd0);
        send(C_HALT, '0);
        check("t3_cause_cmd", {62'd0, halt_cause}, 64'd1);

        // HALT command in the same cycle as a breakpoint hit.
        load_pc(32'h8);
        send(C_RUN, '0);
        repeat (2) tick();
        check("t4_pc_at_bp", {32'd0, pc}, 64'h10);
        cmd_valid = 1'b1;
        cmd_op    = C_HALT;
        cmd_arg   = '0;
        tick();
        cmd_valid = 1'b0;
        check("t4_halted", {63'd0, halted}, 64'd1);
        check("t4_cause", {62'd0, halt_cause}, BP_EN ? 64'd3 : 64'd1);
        send(C_CLR_BP, '0);
        load_pc(32'h8);
        send(C_RUN, '0);
        repeat (6) tick();
        check("t4_clr_bp_runs", {63'd0, halted}, 64'd0);
        send(C_HALT, '0);
        check("t4_cause_cmd", {62'd0, halt_cause}, 64'd1);

        // Counter clear, then reset in the middle of STEP 100.
        send(C_CLR_CNT, '0);
        check("t5_clr_cnt", {32'd0, retired}, 64'd0);
        send(C_SET_BP, 32'h10);
        load_pc(32'h100);
        send(C_STEP, 32'd100);
        repeat (10) tick();
        #2;
        rst_n       = 1'b0;
        pc_load     = 1'b1;
        pc_load_val = 32'h0;
        #1;
        check("t5_rst_en", {63'd0, core_en}, 64'd0);
        check("t5_rst_halted", {63'd0, halted}, 64'd1);
        check("t5_rst_ready", {63'd0, cmd_ready}, 64'd1);
        check("t5_rst_cause", {62'd0, halt_cause}, 64'd0);
        check("t5_rst_retired", {32'd0, retired}, 64'd0);
        repeat (2) tick();
        rst_n   = 1'b1;
        pc_load = 1'b0;
        tick();
        check("t5_post_retired", {32'd0, retired}, 64'd0);
        send(C_RUN, '0);
        repeat (8) tick();
        check("t5_bp_disarmed", {63'd0, halted}, 64'd0);
        check("t5_retired_run", {32'd0, retired}, 64'd8);
        send(C_HALT, '0);

        // Wrap of the 8-bit counter.
        while (cyc8 < 255) tick();
        check("t6_w8_ff", {56'd0, retired8}, 64'hFF);
        tick();
        check("t6_w8_wrap", {56'd0, retired8}, 64'h0);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
